clb_cfg_loader: RTL and testbench

- Configuration sequencer for one K6N10F logic cluster.
- Accepts LUT-mask configuration words over a valid/ready stream and serialises them, MSB first, onto the cluster's LUT-mask shift chain.
- Checks a trailing XOR checksum word. On a match it issues a single commit strobe so the cluster's LUT_K instances adopt the new masks atomically.
- Sits between the fabric configuration bus and the cluster's mask chain.

---
 rtl/qlf_k6n10f_cfg_pkg.sv | 31 +++
 rtl/cfg_piso.sv | 41 ++++
 rtl/clb_cfg_loader.sv | 153 +++++++++++++++
 tb/tb_clb_cfg_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qlf_k6n10f_cfg_pkg.sv
// Purpose: shared types and sizing helpers for the K6N10F cluster config loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   Contents: loader FSM state enum, LUT mask size helpers, config word count helper.
package qlf_k6n10f_cfg_pkg;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SHIFT  = 3'd2,
      CHECK  = 3'd3,
      COMMIT = 3'd4
   } cfg_state_e;

   // Mask bits per LUT for the default 6-input LUT.
   localparam int DEF_K    = 6;
   localparam int LUT_BITS = 2**DEF_K;

   // Mask bits per LUT for an arbitrary LUT input count.
   function automatic int lut_bits(input int k);
      return 1 << k;
   endfunction

   // Stream words needed to fill the whole cluster mask chain.
   // The caller is expected to pick num_luts*2**k divisible by cfg_w.
   function automatic int calc_nwords(input int num_luts, input int k, input int cfg_w);
      return (num_luts * lut_bits(k)) / cfg_w;
   endfunction

endpackage

// File: rtl/cfg_piso.sv
// Purpose: parallel-load, MSB-first shift register with a bit counter for one config word.
// Latency: first bit on dout the cycle after load; last asserted during the final shift cycle.
// Backpressure: none; en shifts one bit per cycle, load has priority over en.
//   Ports: C clock, R sync active-low reset, load/din parallel load, en shift enable,
//          dout current MSB, last high when the bit on dout is the word's final bit.
module cfg_piso #(
   parameter int W = 8
) (
   input  logic         C,
   input  logic         R,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         en,
   output logic         dout,
   output logic         last
);

   localparam int BCW = $clog2(W + 1);

   logic [W-1:0]   sr_q;
   logic [BCW-1:0] cnt_q;

   always_ff @(posedge C) begin
      if (!R) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         sr_q  <= din;
         cnt_q <= BCW'(W);
      end else if (en && (cnt_q != '0)) begin
         // Shift left so the next-lower bit becomes the MSB on dout.
         sr_q  <= sr_q << 1;
         cnt_q <= cnt_q - BCW'(1);
      end
   end

   assign dout = sr_q[W-1];
   // One bit remaining means the current dout is the last of the word.
   assign last = (cnt_q == BCW'(1));

endmodule

// File: rtl/clb_cfg_loader.sv
// Purpose: streams LUT mask words into a K6N10F cluster chain and commits on a good XOR checksum.
// Latency: CFG_W+1 cycles per word; commit strobe NWORDS*(CFG_W+1)+2 cycles after first s_valid.
// Backpressure: s_ready high only in LOAD/CHECK and gated low by abort; no ready while shifting.
//   Ports: C/R clock and sync active-low reset; start/abort control; s_valid/s_data/s_ready
//          config stream; chain_en/chain_dout/chain_commit mask chain; busy/done/err status.
module clb_cfg_loader
   import qlf_k6n10f_cfg_pkg::*;
#(
   parameter int NUM_LUTS = 10,
   parameter int K        = 6,
   parameter int CFG_W    = 8
) (
   input  logic             C,
   input  logic             R,
   input  logic             start,
   input  logic             abort,
   input  logic             s_valid,
   input  logic [CFG_W-1:0] s_data,
   output logic             s_ready,
   output logic             chain_en,
   output logic             chain_dout,
   output logic             chain_commit,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int NWORDS = calc_nwords(NUM_LUTS, K, CFG_W);
   localparam int WCW    = $clog2(NWORDS + 1);
   localparam logic [WCW-1:0] NWORDS_C = WCW'(NWORDS);

   cfg_state_e       state_q, state_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic [CFG_W-1:0] acc_q, acc_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             piso_load;
   logic             piso_dout;
   logic             piso_last;

   cfg_piso #(
      .W (CFG_W)
   ) u_piso (
      .C    (C),
      .R    (R),
      .load (piso_load),
      .din  (s_data),
      .en   (chain_en),
      .dout (piso_dout),
      .last (piso_last)
   );

   always_ff @(posedge C) begin
      if (!R) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         acc_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      acc_d        = acc_q;
      done_d       = done_q;
      err_d        = err_q;
      s_ready      = 1'b0;
      chain_en     = 1'b0;
      chain_commit = 1'b0;
      piso_load    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Simultaneous start+abort is treated as no request.
            if (start && !abort) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               acc_d   = '0;
               wcnt_d  = '0;
               state_d = LOAD;
            end
         end

         LOAD: begin
            s_ready = !abort;
            if (abort) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end else if (s_valid) begin
               piso_load = 1'b1;
               acc_d     = acc_q ^ s_data;
               wcnt_d    = wcnt_q + WCW'(1);
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            // The abort cycle still shifts; chain_en drops from the next cycle.
            chain_en = 1'b1;
            if (abort) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end else if (piso_last) begin
               state_d = (wcnt_q == NWORDS_C) ? CHECK : LOAD;
            end
         end

         CHECK: begin
            // Checksum word is compared only, never shifted into the chain.
            s_ready = !abort;
            if (abort) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end else if (s_valid) begin
               if (s_data == acc_q) begin
                  state_d = COMMIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         COMMIT: begin
            // Abort is deliberately ignored here so the commit is atomic.
            chain_commit = 1'b1;
            done_d       = 1'b1;
            state_d      = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // Gate with chain_en so stale bits from an aborted word never reach the chain.
   assign chain_dout = chain_en & piso_dout;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Purpose: self-checking bench for clb_cfg_loader, small (2-word) and default (80-word) builds.
// Latency: checks the minimal load timing and per-bit chain output against a scoreboard.
// Backpressure: drives s_valid with random throttling on the default build.
module tb_clb_cfg_loader;

   logic C;
   logic R;

   // Small instance: NUM_LUTS=1, K=4, CFG_W=8 -> 2 words.
   logic       s_start, s_abort, s_sv;
   logic [7:0] s_sd;
   logic       s_srdy, s_en, s_dout, s_commit, s_busy, s_done, s_err;

   // Default instance: 80 words.
   logic       d_start, d_abort, d_sv;
   logic [7:0] d_sd;
   logic       d_srdy, d_en, d_dout, d_commit, d_busy, d_done, d_err;

   clb_cfg_loader #(.NUM_LUTS(1), .K(4), .CFG_W(8)) dut_s (
      .C(C), .R(R), .start(s_start), .abort(s_abort), .s_valid(s_sv), .s_data(s_sd),
      .s_ready(s_srdy), .chain_en(s_en), .chain_dout(s_dout), .chain_commit(s_commit),
      .busy(s_busy), .done(s_done), .err(s_err)
   );

   clb_cfg_loader dut_d (
      .C(C), .R(R), .start(d_start), .abort(d_abort), .s_valid(d_sv), .s_data(d_sd),
      .s_ready(d_srdy), .chain_en(d_en), .chain_dout(d_dout), .chain_commit(d_commit),
      .busy(d_busy), .done(d_done), .err(d_err)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge C) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboards: expected chain bits, pushed on each accepted data word.
   logic q_s[$];
   logic q_d[$];
   int   s_commit_cnt = 0, s_commit_cyc = 0;
   int   d_commit_cnt = 0, d_commit_cyc = 0, d_bits = 0;

   always @(negedge C) begin
      if (s_commit) begin
         s_commit_cnt++;
         s_commit_cyc = cyc;
      end
      if (s_en) begin
         if (q_s.size() == 0) chk("s_chain_en_unexpected", 32'(s_en), 32'd0);
         else                 chk("s_chain_dout", 32'(s_dout), 32'(q_s.pop_front()));
      end
   end

   always @(negedge C) begin
      if (d_commit) begin
         d_commit_cnt++;
         d_commit_cyc = cyc;
      end
      if (d_en) begin
         d_bits++;
         if (q_d.size() == 0) chk("d_chain_en_unexpected", 32'(d_en), 32'd0);
         else                 chk("d_chain_dout", 32'(d_dout), 32'(q_d.pop_front()));
      end
   end

   // Present one word and hold it until accepted; returns at posedge+1 after the handshake.
   task automatic send_s(input logic [7:0] w, input bit is_data);
      bit ok;
      ok   = 1'b0;
      s_sv = 1'b1;
      s_sd = w;
      for (int t = 0; t < 40; t++) begin
         @(negedge C);
         if (s_srdy) begin
            if (is_data) for (int b = 7; b >= 0; b--) q_s.push_back(w[b]);
            ok = 1'b1;
            @(posedge C); #1;
            break;
         end
         @(posedge C); #1;
      end
      s_sv = 1'b0;
      chk("s_handshake", 32'(ok), 32'd1);
   endtask

   task automatic send_d(input logic [7:0] w, input bit is_data);
      bit ok;
      ok   = 1'b0;
      d_sv = 1'b1;
      d_sd = w;
      for (int t = 0; t < 40; t++) begin
         @(negedge C);
         if (d_srdy) begin
            if (is_data) for (int b = 7; b >= 0; b--) q_d.push_back(w[b]);
            ok = 1'b1;
            @(posedge C); #1;
            break;
         end
         @(posedge C); #1;
      end
      d_sv = 1'b0;
      chk("d_handshake", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle_s();
      for (int t = 0; t < 30; t++) begin
         @(negedge C);
         if (!s_busy) break;
      end
      chk("s_idle_reached", 32'(s_busy), 32'd0);
      @(posedge C); #1;
   endtask

   typedef struct packed {
      logic [7:0] w0;
      logic [7:0] w1;
      logic [7:0] cs;
      logic [3:0] abort_at;   // 0 = no abort, else SHIFT cycle (1-based) of w0
      logic       exp_commit;
      logic       exp_done;
      logic       exp_err;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];
   vec_t v;
   int   first_cyc;
   logic [7:0] acc;
   logic [7:0] w;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{8'hA5, 8'h3C, 8'h99, 4'd0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'hA5, 8'h3C, 8'h98, 4'd0, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'hA5, 8'h3C, 8'h99, 4'd3, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'hA5, 8'h3C, 8'h99, 4'd0, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'hFF, 8'h00, 8'hFF, 4'd0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'h12, 8'h34, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8'h80, 8'h01, 8'h81, 4'd0, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{8'hC3, 8'h5A, 8'h99, 4'd1, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{8'hC3, 8'h5A, 8'h99, 4'd0, 1'b1, 1'b1, 1'b0};

      R = 1'b0;
      s_start = 0; s_abort = 0; s_sv = 0; s_sd = '0;
      d_start = 0; d_abort = 0; d_sv = 0; d_sd = '0;
      repeat (2) @(posedge C);
      #1;
      chk("rst_s_ready", 32'(s_srdy), 0);
      chk("rst_chain_en", 32'(s_en), 0);
      chk("rst_chain_dout", 32'(s_dout), 0);
      chk("rst_commit", 32'(s_commit), 0);
      chk("rst_busy", 32'(s_busy), 0);
      chk("rst_done", 32'(s_done), 0);
      chk("rst_err", 32'(s_err), 0);
      chk("rst_d_busy", 32'(d_busy), 0);
      R = 1'b1;
      @(posedge C); #1;

      // Table-driven loads on the small instance.
      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         s_commit_cnt = 0;
         s_start = 1'b1;
         @(posedge C); #1;
         s_start = 1'b0;
         chk("start_busy", 32'(s_busy), 1);
         chk("start_clears_err", 32'(s_err), 0);
         chk("start_clears_done", 32'(s_done), 0);
         first_cyc = cyc;
         send_s(v.w0, 1'b1);
         if (v.abort_at != 4'd0) begin
            repeat (int'(v.abort_at) - 1) begin @(posedge C); #1; end
            s_abort = 1'b1;
            @(posedge C); #1;
            s_abort = 1'b0;
            chk("abort_chain_en_low", 32'(s_en), 0);
            chk("abort_idle", 32'(s_busy), 0);
            q_s.delete();
         end else begin
            send_s(v.w1, 1'b1);
            send_s(v.cs, 1'b0);
            wait_idle_s();
            if (v.exp_commit) chk("min_load_cycles", 32'(s_commit_cyc - first_cyc + 1), 32'd20);
         end
         chk("commit_count", 32'(s_commit_cnt), 32'(v.exp_commit));
         chk("done", 32'(s_done), 32'(v.exp_done));
         chk("err", 32'(s_err), 32'(v.exp_err));
         chk("busy_end", 32'(s_busy), 0);
         chk("bits_left", 32'(q_s.size()), 0);
         @(posedge C); #1;
      end

      // start+abort together in IDLE: no transition.
      s_start = 1'b1; s_abort = 1'b1;
      @(posedge C); #1;
      s_start = 1'b0; s_abort = 1'b0;
      chk("start_abort_idle", 32'(s_busy), 0);

      // abort gates s_ready in LOAD even with a word presented.
      s_start = 1'b1;
      @(posedge C); #1;
      s_start = 1'b0;
      s_sv = 1'b1; s_sd = 8'h55; s_abort = 1'b1;
      #1;
      chk("abort_gates_ready", 32'(s_srdy), 0);
      @(posedge C); #1;
      s_sv = 1'b0; s_abort = 1'b0;
      chk("abort_load_idle", 32'(s_busy), 0);
      chk("abort_load_no_shift", 32'(s_en), 0);
      @(posedge C); #1;

      // start held high for a whole load: no restart while busy.
      s_commit_cnt = 0;
      s_start = 1'b1;
      @(posedge C); #1;
      first_cyc = cyc;
      send_s(8'hA5, 1'b1);
      send_s(8'h3C, 1'b1);
      send_s(8'h99, 1'b0);
      for (int t = 0; t < 30; t++) begin
         @(negedge C);
         if (s_commit) break;
      end
      @(posedge C); #1;
      s_start = 1'b0;
      @(posedge C); #1;
      chk("hold_start_commit", 32'(s_commit_cnt), 1);
      chk("hold_start_cycles", 32'(s_commit_cyc - first_cyc + 1), 32'd20);
      chk("hold_start_done", 32'(s_done), 1);
      chk("hold_start_no_restart", 32'(s_busy), 0);

      // Reset pulse while in CHECK.
      s_commit_cnt = 0;
      s_start = 1'b1;
      @(posedge C); #1;
      s_start = 1'b0;
      send_s(8'hA5, 1'b1);
      send_s(8'h3C, 1'b1);
      repeat (8) begin @(posedge C); #1; end
      chk("in_check_ready", 32'(s_srdy), 1);
      R = 1'b0;
      @(posedge C); #1;
      R = 1'b1;
      chk("rst_mid_ready", 32'(s_srdy), 0);
      chk("rst_mid_chain_en", 32'(s_en), 0);
      chk("rst_mid_dout", 32'(s_dout), 0);
      chk("rst_mid_commit", 32'(s_commit), 0);
      chk("rst_mid_busy", 32'(s_busy), 0);
      chk("rst_mid_done", 32'(s_done), 0);
      chk("rst_mid_err", 32'(s_err), 0);
      s_sv = 1'b1; s_sd = 8'h99;
      #1;
      chk("rst_mid_csum_refused", 32'(s_srdy), 0);
      repeat (3) begin @(posedge C); #1; end
      s_sv = 1'b0;
      chk("rst_mid_no_commit", 32'(s_commit_cnt), 0);
      chk("rst_mid_still_idle", 32'(s_busy), 0);

      // Default build: 80 random words, throttled, plus correct checksum.
      d_commit_cnt = 0; d_bits = 0; acc = '0;
      d_start = 1'b1;
      @(posedge C); #1;
      d_start = 1'b0;
      first_cyc = 0;
      for (int i = 0; i <= 80; i++) begin
         if (i < 80) begin
            w   = 8'($urandom);
            acc = acc ^ w;
         end else begin
            w = acc;
         end
         repeat ($urandom_range(0, 3)) begin @(posedge C); #1; end
         if (i == 0) first_cyc = cyc;
         send_d(w, i < 80);
      end
      for (int t = 0; t < 30; t++) begin
         @(negedge C);
         if (!d_busy) break;
      end
      @(posedge C); #1;
      chk("d_idle_reached", 32'(d_busy), 0);
      chk("d_commit_once", 32'(d_commit_cnt), 1);
      chk("d_done", 32'(d_done), 1);
      chk("d_err", 32'(d_err), 0);
      chk("d_bits_shifted", 32'(d_bits), 32'd640);
      chk("d_bits_left", 32'(q_d.size()), 0);
      chk("d_cycles_ge_722", 32'((d_commit_cyc - first_cyc + 1) >= 722), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
